// File: rtl/packing_merge_pipe_if.sv
// Block-level handshake and data bundle for packing_merge_pipe.
// The slave modport is the pipeline side and the master modport is the producer/consumer side.
interface packing_merge_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LANES      = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) ();
    logic                        in_valid;
    logic                        in_ready;
    logic                        bypass;
    logic [LANES*DATA_WIDTH-1:0] dataIn;
    logic [LANES*DATA_WIDTH-1:0] cprDataIn;
    logic [LANES*TAG_WIDTH-1:0]  tagIn;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*DATA_WIDTH-1:0] dataOut;
    logic [LANES*TAG_WIDTH-1:0]  tagOut;
    logic [LEN_WIDTH-1:0]        lenOut;
    logic [CNT_WIDTH-1:0]        blk_count;

    modport slave (
        input  in_valid, bypass, dataIn, cprDataIn, tagIn, out_ready,
        output in_ready, out_valid, dataOut, tagOut, lenOut, blk_count
    );

    modport master (
        output in_valid, bypass, dataIn, cprDataIn, tagIn, out_ready,
        input  in_ready, out_valid, dataOut, tagOut, lenOut, blk_count
    );
endinterface

// File: rtl/packing_merge_pipe.sv
// Pipelined lane packer: tags become bit lengths, and a registered binary merge tree
// concatenates the valid bits of every lane MSB-first. The whole pipeline stalls together.
module packing_merge_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LANES      = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    packing_merge_pipe_if.slave  bus
);
    localparam int STAGES = $clog2(LANES);
    localparam int TOT_W  = LANES * DATA_WIDTH;
    localparam int TOT_T  = LANES * TAG_WIDTH;

    localparam logic [LEN_WIDTH-1:0] LEN_FULL = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_HALF = LEN_WIDTH'(DATA_WIDTH / 2);
    localparam logic [LEN_WIDTH-1:0] LEN_QTR  = LEN_WIDTH'(DATA_WIDTH / 4);

    if (DATA_WIDTH % 4 != 0) begin : g_chk_dw
        $error("DATA_WIDTH must be a multiple of 4");
    end
    if (LANES < 2 || (1 << STAGES) != LANES) begin : g_chk_lanes
        $error("LANES must be a power of 2 and at least 2");
    end
    if (LEN_WIDTH < $clog2(TOT_W + 1)) begin : g_chk_len
        $error("LEN_WIDTH too narrow for LANES*DATA_WIDTH");
    end

    // Every stage advances together; a held output freezes the whole pipe.
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    logic [TOT_W-1:0]                  front_data;
    logic [TOT_T-1:0]                  front_tag;
    logic [LANES-1:0][LEN_WIDTH-1:0]   front_len;

    // Each lane is left-aligned in its slot; shifting out the upper bits also masks them.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        front_data = '0;
        front_len  = '0;
        front_tag  = bus.bypass ? '1 : bus.tagIn;
        for (int i = 0; i < LANES; i++) begin
            case (front_tag[i*TAG_WIDTH +: TAG_WIDTH])
                TAG_WIDTH'(0): front_len[i] = '0;
                TAG_WIDTH'(1): front_len[i] = LEN_QTR;
                TAG_WIDTH'(2): front_len[i] = LEN_HALF;
                default:       front_len[i] = LEN_FULL;
            endcase
            front_data[i*DATA_WIDTH +: DATA_WIDTH] =
                (bus.bypass ? bus.dataIn[i*DATA_WIDTH +: DATA_WIDTH]
                            : bus.cprDataIn[i*DATA_WIDTH +: DATA_WIDTH])
                << (LEN_FULL - front_len[i]);
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int CW    = DATA_WIDTH << s;
        localparam int NODES = LANES >> (s + 1);

        logic [TOT_W-1:0]                  src_data, merge_data, data_d, data_q;
        logic [TOT_T-1:0]                  src_tag, tag_d, tag_q;
        logic [2*NODES-1:0][LEN_WIDTH-1:0] src_len;
        logic [NODES-1:0][LEN_WIDTH-1:0]   merge_len, len_d, len_q;
        logic                              src_valid, valid_d, valid_q;

        if (s == 0) begin : g_src
            assign src_data  = front_data;
            assign src_tag   = front_tag;
            assign src_len   = front_len;
            assign src_valid = bus.in_valid;
        end else begin : g_src
            assign src_data  = g_stage[s-1].data_q;
            assign src_tag   = g_stage[s-1].tag_q;
            assign src_len   = g_stage[s-1].len_q;
            assign src_valid = g_stage[s-1].valid_q;
        end

        // Children are MSB-aligned with zero tails, so the low child is OR-ed in right after the high one.
        always_comb begin
            merge_data = '0;
            merge_len  = '0;
            for (int n = 0; n < NODES; n++) begin
                merge_data[2*CW*n +: 2*CW] =
                    {src_data[2*CW*n + CW +: CW], {CW{1'b0}}}
                  | ({src_data[2*CW*n +: CW], {CW{1'b0}}} >> src_len[2*n+1]);
                merge_len[n] = src_len[2*n+1] + src_len[2*n];
            end
        end

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            tag_d   = tag_q;
            len_d   = len_q;
            if (adv) begin
                valid_d = src_valid;
                data_d  = merge_data;
                tag_d   = src_tag;
                len_d   = merge_len;
            end
        end

        always_ff @(posedge clk) begin
            // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
                len_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                tag_q   <= tag_d;
                len_q   <= len_d;
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.dataOut   = g_stage[STAGES-1].data_q;
    assign bus.tagOut    = g_stage[STAGES-1].tag_q;
    assign bus.lenOut    = g_stage[STAGES-1].len_q[0];

    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q + CNT_WIDTH'(bus.out_valid && bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.blk_count = cnt_q;
endmodule
